// File: rtl/code_pkg.sv
// Shared defaults for the two-channel counter block.
package code_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int DIV_DEF   = 4;
endpackage

// File: rtl/code_cnt.sv
// Single WIDTH-bit counter: increment enable, wrap, async clear.
module code_cnt
  import code_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/code.sv
// Two-channel counter; channel 1 advances once per DIV selected cycles.
module code
  import code_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV   = DIV_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Slt,
  input  logic             En,
  output logic [WIDTH-1:0] Output0,
  output logic [WIDTH-1:0] Output1
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;
  logic          wrap;
  logic          inc0;
  logic          inc1;

  assign wrap = (pre == PW'(DIV - 1));
  assign inc0 = En & ~Slt;
  assign inc1 = En & Slt & wrap;

  // Prescaler only moves on selected channel-1 cycles, so progress survives Slt toggles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      pre <= '0;
    else if (En && Slt)
      pre <= wrap ? '0 : pre + PW'(1);
  end

  code_cnt #(.WIDTH(WIDTH)) u_cnt0 (
    .clk  (Clk),
    .rst  (Reset),
    .inc  (inc0),
    .count(Output0)
  );

  code_cnt #(.WIDTH(WIDTH)) u_cnt1 (
    .clk  (Clk),
    .rst  (Reset),
    .inc  (inc1),
    .count(Output1)
  );

endmodule

// File: tb/tb_code.sv
// Directed bench for the two-channel counter, default and WIDTH=4.
module tb_code;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Slt = 1'b0;
  logic        En = 1'b0;
  logic        slt4 = 1'b0;
  logic        en4 = 1'b0;
  logic [63:0] o0;
  logic [63:0] o1;
  logic [3:0]  q0;
  logic [3:0]  q1;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  code dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Slt    (Slt),
    .En     (En),
    .Output0(o0),
    .Output1(o1)
  );

  code #(.WIDTH(4)) dut4 (
    .Clk    (Clk),
    .Reset  (Reset),
    .Slt    (slt4),
    .En     (en4),
    .Output0(q0),
    .Output1(q1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_o0", o0, 64'd0);
    chk("rst_o1", o1, 64'd0);
    step(1);
    Reset = 1'b0;

    En = 1'b1;
    Slt = 1'b0;
    step(1);
    chk("c0_a", o0, 64'd1);
    step(1);
    chk("c0_b", o0, 64'd2);
    chk("c0_b_o1", o1, 64'd0);

    Slt = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("pre_hold_o1", o1, 64'd0);
    end
    step(1);
    chk("div4_o1", o1, 64'd1);
    chk("div4_o0", o0, 64'd2);

    #3 Reset = 1'b1;
    #1;
    chk("async_o0", o0, 64'd0);
    chk("async_o1", o1, 64'd0);
    step(1);
    chk("rst_hold_o0", o0, 64'd0);
    Reset = 1'b0;
    step(3);
    chk("post_rst_3", o1, 64'd0);
    step(1);
    chk("post_rst_4_o1", o1, 64'd1);
    chk("post_rst_4_o0", o0, 64'd0);

    step(2);
    Slt = 1'b0;
    step(3);
    chk("keep_o0", o0, 64'd3);
    Slt = 1'b1;
    step(1);
    chk("keep_a", o1, 64'd1);
    step(1);
    chk("keep_b", o1, 64'd2);
    chk("keep_b_o0", o0, 64'd3);

    step(3);
    En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Slt = ~Slt;
      step(1);
    end
    chk("en0_o0", o0, 64'd3);
    chk("en0_o1", o1, 64'd2);
    En = 1'b1;
    Slt = 1'b1;
    step(1);
    chk("en0_pre_kept", o1, 64'd3);

    step(2);
    #3 Reset = 1'b1;
    #1;
    chk("mid_rst_o1", o1, 64'd0);
    #2 Reset = 1'b0;
    step(3);
    chk("mid_rst_3", o1, 64'd0);
    step(1);
    chk("mid_rst_4", o1, 64'd1);

    En = 1'b0;
    en4 = 1'b1;
    slt4 = 1'b0;
    step(15);
    chk("w4_15", {60'd0, q0}, 64'd15);
    step(1);
    chk("w4_wrap", {60'd0, q0}, 64'd0);
    chk("w4_o1", {60'd0, q1}, 64'd0);
    en4 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/code.md
CODE -- requirements
Module: code

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the width of both count outputs.
REQ-002 Parameter DIV, default 4, SHALL set how many enabled Slt=1 cycles make one Output1 increment; legal values are 2 or greater.
REQ-003 Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Slt  input  1  SHALL select the channel: 0 selects Output0, 1 selects Output1.
REQ-006 En  input  1  SHALL be the count enable; 0 holds all state.
REQ-007 Output0  output  WIDTH  SHALL carry the channel-0 count, driven directly from a register.
REQ-008 Output1  output  WIDTH  SHALL carry the channel-1 count, driven directly from a register.

Function
REQ-009 The block SHALL contain an internal prescaler of width clog2(DIV), which is not visible at the ports.
REQ-010 On a rising edge with En=1 and Slt=0, Output0 SHALL increment by 1; Output1 and the prescaler SHALL hold.
REQ-011 On a rising edge with En=1 and Slt=1, Output0 SHALL hold and the prescaler SHALL update as follows:
- prescaler below DIV-1: prescaler increments by 1.
- prescaler equal to DIV-1: prescaler returns to 0 and Output1 increments by 1 on that same edge.
REQ-012 With default parameters, Output1 SHALL increment on every 4th enabled Slt=1 edge, counting from reset.
REQ-013 On a rising edge with En=0, Output0, Output1 and the prescaler SHALL all hold, whatever the value of Slt.
REQ-014 Any change of Slt SHALL leave the prescaler unchanged, so partial progress toward the next Output1 increment is kept.
REQ-015 Both outputs SHALL wrap modulo 2^WIDTH: the value all-ones plus 1 becomes 0, with no carry or flag output.
REQ-016 A new output value SHALL be visible one clock after the enabling edge, i.e. one cycle of latency; there is no combinational path from any input to any output.
REQ-017 Only one of Output0 or Output1 SHALL change on any given edge.

Reset
REQ-018 Reset=1 SHALL immediately clear Output0, Output1 and the prescaler to 0, without waiting for a clock edge.
REQ-019 While Reset=1, all state SHALL stay at 0 regardless of En and Slt.
REQ-020 Reset SHALL take priority over counting, including when it is asserted partway through a prescaler sequence.
REQ-021 After Reset is deasserted, counting SHALL resume on the first rising edge with the prescaler starting from 0.

Structure
REQ-022 The default values of WIDTH and DIV SHALL be defined in a shared package named code_pkg.
REQ-023 A single sub-module, code_cnt, SHALL implement one WIDTH-bit counter with increment enable, wrap-around and asynchronous clear.
REQ-024 code SHALL instantiate code_cnt twice, once per channel.
REQ-025 The prescaler and the per-channel enable decode SHALL be implemented in the code top level.

Verification
REQ-026 Reset pulse, then 2 edges with En=1, Slt=0 -> Output0=1, then 2; Output1=0.
REQ-027 Continuing, set Slt=1 for 4 edges -> Output1 stays 0 for 3 edges, becomes 1 on the 4th edge; Output0 holds at 2.
REQ-028 Assert Reset between clock edges -> both outputs read 0 before the next edge; after deassertion, 4 edges with Slt=1 -> Output0=0, Output1=1.
REQ-029 Apply 2 edges with Slt=1, then 3 edges with Slt=0, then 2 edges with Slt=1 -> Output1 increments on the final edge, showing the prescaler was kept; Output0 rises by 3.
REQ-030 Hold En=0 for 5 edges while toggling Slt -> Output0, Output1 and the prescaler do not change.
REQ-031 Use WIDTH=4 with Output0 counted to 15, then 1 more edge with Slt=0 -> Output0=0.
